// File: rtl/clock_enable_bank.sv
// clock_enable_bank: CH independent programmable clock-enable strobes from one system clock.
// Each channel has its own divisor, run gate, and periodic or one-shot mode.
module clock_enable_bank #(
    parameter int  CH          = 4,
    parameter int  N           = 16,
    parameter int  DEFAULT_DIV = 16,
    localparam int CW          = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            cfg_we,
    input  logic [CW-1:0]   cfg_ch,
    input  logic [N-1:0]    cfg_div,
    input  logic            cfg_oneshot,
    input  logic [CH-1:0]   run,
    input  logic            sync_clear,
    output logic [CH-1:0]   ce,
    output logic [CH-1:0]   busy,
    output logic [CH*N-1:0] q
);

    logic [N-1:0]  div_q [CH];
    logic [N-1:0]  div_d [CH];
    logic [N-1:0]  cnt_q [CH];
    logic [N-1:0]  cnt_d [CH];
    logic [CH-1:0] mode_q, mode_d;
    logic [CH-1:0] armed_q, armed_d;
    logic [CH-1:0] active, at_top;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch can leave it unassigned and infer a latch.
        ce      = '0;
        busy    = '0;
        q       = '0;
        active  = '0;
        at_top  = '0;
        mode_d  = mode_q;
        armed_d = armed_q;
        for (int i = 0; i < CH; i++) begin
            div_d[i] = div_q[i];
            cnt_d[i] = cnt_q[i];
        end

        for (int i = 0; i < CH; i++) begin
            active[i]   = run[i] && (div_q[i] != '0) && (!mode_q[i] || armed_q[i]);
            at_top[i]   = (cnt_q[i] == div_q[i] - N'(1));
            busy[i]     = active[i];
            ce[i]       = active[i] && at_top[i] && !sync_clear;
            q[i*N +: N] = cnt_q[i];

            // A clear beats everything for the counter but never consumes a one-shot.
            if (cfg_we && (int'(cfg_ch) == i)) begin
                div_d[i]   = cfg_div;
                mode_d[i]  = cfg_oneshot;
                armed_d[i] = cfg_oneshot;
                cnt_d[i]   = '0;
            end else if (!sync_clear && active[i] && at_top[i]) begin
                cnt_d[i] = '0;
                if (mode_q[i]) begin
                    armed_d[i] = 1'b0;
                end
            end else if (!sync_clear && active[i]) begin
                cnt_d[i] = cnt_q[i] + N'(1);
            end

            if (sync_clear) begin
                cnt_d[i] = '0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every channel updates from the same pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the per-channel arrays are small flop banks, not RAM, so they are reset like any other register.
            for (int i = 0; i < CH; i++) begin
                div_q[i] <= N'(DEFAULT_DIV);
                cnt_q[i] <= '0;
            end
            mode_q  <= '0;
            armed_q <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                div_q[i] <= div_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            mode_q  <= mode_d;
            armed_q <= armed_d;
        end
    end

endmodule

// File: tb/tb_clock_enable_bank.sv
// Scoreboard bench for clock_enable_bank: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_clock_enable_bank;

    localparam int CH = 4;
    localparam int N  = 16;

    typedef enum logic [2:0] {K_CE, K_CEV, K_BUSY, K_BUSYV, K_Q, K_QALL, K_CE3, K_Q3} kind_e;

    typedef struct {
        int          cyc;
        kind_e       kind;
        int          ch;
        logic [63:0] exp;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cfg_we;
    logic [1:0]    cfg_ch;
    logic [N-1:0]  cfg_div;
    logic          cfg_oneshot;
    logic [CH-1:0] run;
    logic          sync_clear;
    logic [CH-1:0] ce;
    logic [CH-1:0] busy;
    logic [CH*N-1:0] q;

    logic          d3_we;
    logic [1:0]    d3_ch;
    logic [7:0]    d3_div;
    logic          d3_os;
    logic [2:0]    ce3;
    logic [2:0]    busy3;
    logic [23:0]   q3;

    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    clock_enable_bank #(.CH(CH), .N(N), .DEFAULT_DIV(16)) u_dut (
        .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
        .cfg_oneshot(cfg_oneshot), .run(run), .sync_clear(sync_clear),
        .ce(ce), .busy(busy), .q(q)
    );

    // Three channels: channel code 3 is representable but out of range.
    clock_enable_bank #(.CH(3), .N(8), .DEFAULT_DIV(5)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .cfg_we(d3_we), .cfg_ch(d3_ch), .cfg_div(d3_div),
        .cfg_oneshot(d3_os), .run(3'b111), .sync_clear(1'b0),
        .ce(ce3), .busy(busy3), .q(q3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #50000;
        $display("FAIL watchdog: cycle %0d reached, limit 5000", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input bit ok, input string what, input int ch, input int at,
                         input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s ch%0d cyc%0d (now %0d): got 0x%0h, expected 0x%0h", what, ch, at, cyc, act, exp);
        end
    endtask

    function automatic logic [63:0] actual(input kind_e k, input int ch);
        case (k)
            K_CE:    return 64'(ce[ch]);
            K_CEV:   return 64'(ce);
            K_BUSY:  return 64'(busy[ch]);
            K_BUSYV: return 64'(busy);
            K_Q:     return 64'(q[ch*N +: N]);
            K_QALL:  return 64'(q);
            K_CE3:   return 64'(ce3[ch]);
            K_Q3:    return 64'(q3[ch*8 +: 8]);
            default: return '0;
        endcase
    endfunction

    // Sorted insert keeps the queue ordered by cycle regardless of push order.
    task automatic expect_at(input int at, input kind_e k, input int ch, input logic [63:0] v);
        exp_t e;
        int   idx;
        bit   found;
        e.cyc  = at;
        e.kind = k;
        e.ch   = ch;
        e.exp  = v;
        idx    = sb.size();
        found  = 1'b0;
        for (int j = 0; j < sb.size(); j++) begin
            if (!found && sb[j].cyc > at) begin
                idx   = j;
                found = 1'b1;
            end
        end
        sb.insert(idx, e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [63:0] act;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e   = sb.pop_front();
            act = actual(e.kind, e.ch);
            check((e.cyc == cyc) && (act === e.exp), e.kind.name(), e.ch, e.cyc, act, e.exp);
        end
    end

    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg(input int ch, input int div, input bit os);
        cfg_ch      = 2'(ch);
        cfg_div     = N'(div);
        cfg_oneshot = os;
        cfg_we      = 1'b1;
        @(posedge clk);
        #1;
        cfg_we      = 1'b0;
    endtask

    task automatic d3cfg(input int ch, input int div, input bit os);
        d3_ch  = 2'(ch);
        d3_div = 8'(div);
        d3_os  = os;
        d3_we  = 1'b1;
        @(posedge clk);
        #1;
        d3_we  = 1'b0;
    endtask

    initial begin : stim
        int   b;
        int   r1;
        exp_t e;

        reset_n = 1'b0; run = '0; sync_clear = 1'b0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_oneshot = 1'b0;
        d3_we = 1'b0; d3_ch = '0; d3_div = '0; d3_os = 1'b0;

        // Reset state: counters zero, no strobes, busy follows run.
        @(posedge clk);
        #1;
        run = '1;
        expect_at(cyc, K_QALL, 0, 64'h0);
        expect_at(cyc, K_CEV, 0, 64'h0);
        expect_at(cyc, K_BUSYV, 0, 64'hF);

        goto(3);
        reset_n = 1'b1;
        b = cyc;
        expect_at(b,      K_Q,   0, 0);
        expect_at(b + 5,  K_Q,   0, 5);
        expect_at(b + 14, K_CE,  0, 0);
        expect_at(b + 15, K_CEV, 0, 64'hF);
        expect_at(b + 16, K_CE,  0, 0);
        expect_at(b + 31, K_CE,  0, 1);
        expect_at(b + 47, K_CE,  0, 1);
        expect_at(b + 54, K_Q,   0, 6);

        // Asynchronous reset mid-count clears immediately.
        goto(b + 55);
        reset_n = 1'b0;
        expect_at(cyc, K_QALL, 0, 64'h0);
        expect_at(cyc, K_CEV, 0, 64'h0);
        goto(b + 57);
        reset_n = 1'b1;
        r1 = cyc;

        // Periodic: ch1 div=3, ch2 div=1.
        goto(cyc + 2);
        b = cyc;
        for (int j = 1; j <= 9; j++) expect_at(b + j, K_CE, 1, 64'((j % 3) == 0));
        expect_at(b + 1, K_Q, 1, 0);
        expect_at(b + 2, K_Q, 1, 1);
        expect_at(b + 3, K_Q, 1, 2);
        expect_at(b + 4, K_Q, 1, 0);
        for (int j = 2; j <= 6; j++) expect_at(b + j, K_CE, 2, 1);
        expect_at(b + 3, K_Q, 2, 0);
        cfg(1, 3, 1'b0);
        cfg(2, 1, 1'b0);

        // Pause ch1 (div=5) at cnt=2 for 7 cycles, then resume.
        goto(b + 10);
        b = cyc;
        for (int j = 1; j <= 3; j++) expect_at(b + j, K_Q, 1, 64'(j - 1));
        for (int j = 3; j <= 10; j++) expect_at(b + j, K_Q, 1, 2);
        for (int j = 3; j <= 9; j++) expect_at(b + j, K_CE, 1, 0);
        expect_at(b + 3,  K_BUSY, 1, 0);
        expect_at(b + 9,  K_BUSY, 1, 0);
        expect_at(b + 10, K_BUSY, 1, 1);
        expect_at(b + 11, K_CE, 1, 0);
        expect_at(b + 12, K_CE, 1, 1);
        expect_at(b + 13, K_CE, 1, 0);
        expect_at(b + 13, K_Q,  1, 0);
        expect_at(b + 17, K_CE, 1, 1);
        cfg(1, 5, 1'b0);
        goto(b + 3);
        run[1] = 1'b0;
        goto(b + 10);
        run[1] = 1'b1;

        // One-shot ch3 div=4, re-arm, and restart while armed.
        goto(b + 20);
        b = cyc;
        for (int j = 1; j <= 4; j++) expect_at(b + j, K_BUSY, 3, 1);
        for (int j = 1; j <= 3; j++) expect_at(b + j, K_CE, 3, 0);
        expect_at(b + 4, K_CE, 3, 1);
        expect_at(b + 5, K_BUSY, 3, 0);
        for (int j = 5; j <= 24; j++) expect_at(b + j, K_CE, 3, 0);
        expect_at(b + 10, K_Q, 3, 0);
        expect_at(b + 28, K_CE, 3, 0);
        expect_at(b + 29, K_CE, 3, 1);
        expect_at(b + 30, K_CE, 3, 0);
        expect_at(b + 30, K_BUSY, 3, 0);
        expect_at(b + 33, K_Q, 3, 1);
        expect_at(b + 35, K_CE, 3, 0);
        expect_at(b + 36, K_CE, 3, 0);
        expect_at(b + 37, K_CE, 3, 1);
        cfg(3, 4, 1'b1);
        goto(b + 25);
        cfg(3, 4, 1'b1);
        goto(b + 31);
        cfg(3, 4, 1'b1);
        goto(b + 33);
        cfg(3, 4, 1'b1);

        // Reconfigure ch0 mid-count, then phase-align ch0/ch1 with sync_clear.
        goto(b + 40);
        b = cyc;
        expect_at(b + 11, K_Q,  0, 10);
        expect_at(b + 12, K_Q,  0, 0);
        expect_at(b + 14, K_CE, 0, 0);
        expect_at(b + 15, K_CE, 0, 1);
        expect_at(b + 16, K_CE, 1, 1);
        expect_at(b + 19, K_CEV, 0, 64'h0);
        expect_at(b + 20, K_Q,  0, 0);
        expect_at(b + 20, K_Q,  1, 0);
        expect_at(b + 20, K_CE, 1, 0);
        expect_at(b + 22, K_CE, 0, 0);
        expect_at(b + 22, K_CE, 1, 0);
        expect_at(b + 23, K_CE, 0, 1);
        expect_at(b + 23, K_CE, 1, 1);
        expect_at(b + 27, K_CE, 0, 1);
        expect_at(b + 27, K_CE, 1, 1);
        cfg(0, 16, 1'b0);
        goto(b + 11);
        cfg(0, 4, 1'b0);
        cfg(1, 4, 1'b0);
        goto(b + 19);
        sync_clear = 1'b1;
        @(posedge clk);
        #1;
        sync_clear = 1'b0;

        // div=0 makes ch2 inert; cfg_we together with sync_clear.
        goto(b + 30);
        b = cyc;
        expect_at(b, K_CE, 2, 1);
        for (int j = 1; j <= 5; j++) begin
            expect_at(b + j, K_BUSY, 2, 0);
            expect_at(b + j, K_CE, 2, 0);
        end
        expect_at(b + 5, K_Q, 2, 0);
        expect_at(b + 2, K_CEV, 0, 64'h0);
        expect_at(b + 3, K_Q, 1, 0);
        expect_at(b + 3, K_Q, 0, 0);
        expect_at(b + 5, K_CE, 1, 0);
        expect_at(b + 5, K_CE, 0, 0);
        expect_at(b + 6, K_CE, 0, 1);
        expect_at(b + 8, K_CE, 1, 1);
        expect_at(b + 14, K_CE, 1, 1);
        cfg(2, 0, 1'b0);
        goto(b + 2);
        sync_clear = 1'b1;
        cfg(1, 6, 1'b0);
        sync_clear = 1'b0;

        // Out-of-range channel write on the three-channel instance is ignored.
        goto(b + 20);
        b = cyc;
        expect_at(b + 1,  K_Q3,  0, 0);
        expect_at(b + 3,  K_Q3,  0, 2);
        expect_at(b + 4,  K_Q3,  0, 3);
        expect_at(b + 4,  K_CE3, 0, 0);
        expect_at(b + 5,  K_CE3, 0, 1);
        expect_at(b + 9,  K_CE3, 0, 0);
        expect_at(b + 10, K_CE3, 0, 1);
        for (int j = 3; j <= 12; j++) begin
            expect_at(b + j, K_CE3, 1, 64'(((b + j - r1) % 5) == 4));
            expect_at(b + j, K_CE3, 2, 64'(((b + j - r1) % 5) == 4));
        end
        d3cfg(0, 5, 1'b0);
        goto(b + 2);
        d3cfg(3, 2, 1'b1);

        goto(b + 20);
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(1'b0, "never_sampled", e.ch, e.cyc, 64'h0, e.exp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
